// File: rtl/att_pkg.sv
// Shared constants and types for the attenuator serial receiver.
//   ATT_WORD_W      default attenuation word length
//   ATT_RESET_WORD  default parallel word after reset
//   ATT_TIMEOUT_CYC default idle-cycle limit for a partial frame
//   att_state_e     receiver frame state
package att_pkg;

  localparam int ATT_WORD_W      = 6;
  localparam int ATT_RESET_WORD  = 0;
  localparam int ATT_TIMEOUT_CYC = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } att_state_e;

endpackage

// File: rtl/att_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin plus a registered
// rising-edge detector on the synchronized level.
//   clk_i   block clock
//   rst_i   synchronous active-high reset (clears every flop)
//   d_i     asynchronous pin
//   mask_i  suppresses rise detection (used right after reset release)
//   sync_o  synchronized pin level (SYNC_STAGES cycles behind d_i)
//   rise_o  one-cycle pulse, one cycle after sync_o goes 0->1
module att_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  input  logic mask_i,
  output logic sync_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q & ~mask_i;
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = rise_q;

endmodule

// File: rtl/att_serial_rx.sv
// Pin-level receiver for the attenuator serial programming interface.
// SI is shifted MSB-first on each serial CLK rise while LE is low; an LE
// rise latches a complete WORD_W-bit frame onto ATT_WORD, or flags a
// short/overrun frame. A partial frame idle for TIMEOUT_CYC cycles is dropped.
//   CLK_ATT    block clock
//   RST        synchronous active-high reset
//   SI/CLK/LE  asynchronous serial pins
//   ATT_WORD   latched attenuation word
//   ATT_VALID  one-cycle pulse when ATT_WORD updates
//   FRAME_ERR  one-cycle pulse on a rejected or timed-out frame
//   BUSY       high while a partial frame is held
module att_serial_rx
  import att_pkg::*;
#(
  parameter int                WORD_W      = ATT_WORD_W,
  parameter int                SYNC_STAGES = 2,
  parameter int                TIMEOUT_CYC = ATT_TIMEOUT_CYC,
  parameter logic [WORD_W-1:0] RESET_WORD  = WORD_W'(ATT_RESET_WORD)
) (
  input  logic              CLK_ATT,
  input  logic              RST,
  input  logic              SI,
  input  logic              CLK,
  input  logic              LE,
  output logic [WORD_W-1:0] ATT_WORD,
  output logic              ATT_VALID,
  output logic              FRAME_ERR,
  output logic              BUSY
);

  localparam int CNT_W = $clog2(WORD_W + 2);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int MSK_W = $clog2(SYNC_STAGES + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(WORD_W + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [MSK_W-1:0] MSK_INIT = MSK_W'(SYNC_STAGES + 1);

  logic si_sync, si_rise_unused;
  logic clk_sync_unused, clk_rise;
  logic le_sync, le_rise;
  logic edge_mask;

  att_state_e        state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [MSK_W-1:0]  msk_q, msk_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  // Pins already high when reset releases would otherwise look like a
  // rise once the synchronizer fills; hold detection off until it settles.
  assign edge_mask = (msk_q != '0);
  assign msk_d     = edge_mask ? msk_q - MSK_W'(1) : msk_q;

  att_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_si (
    .clk_i (CLK_ATT), .rst_i (RST), .d_i (SI), .mask_i (edge_mask),
    .sync_o (si_sync), .rise_o (si_rise_unused)
  );

  att_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk_i (CLK_ATT), .rst_i (RST), .d_i (CLK), .mask_i (edge_mask),
    .sync_o (clk_sync_unused), .rise_o (clk_rise)
  );

  att_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_le (
    .clk_i (CLK_ATT), .rst_i (RST), .d_i (LE), .mask_i (edge_mask),
    .sync_o (le_sync), .rise_o (le_rise)
  );

  // State register
  always_ff @(posedge CLK_ATT) begin
    if (RST) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      word_q  <= RESET_WORD;
      cnt_q   <= '0;
      tmo_q   <= '0;
      msk_q   <= MSK_INIT;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      msk_q   <= msk_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (le_rise) begin
      // LE wins over a coincident CLK rise: that bit is dropped.
      state_d = ST_HOLD;
      cnt_d   = '0;
      if (cnt_q == CNT_FULL) begin
        word_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (clk_rise && !le_sync) begin
            shreg_d = {shreg_q[WORD_W-2:0], si_sync};
            cnt_d   = CNT_W'(1);
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (clk_rise && !le_sync) begin
            shreg_d = {shreg_q[WORD_W-2:0], si_sync};
            // Saturate one past full so any extra bits read as overrun.
            cnt_d   = (cnt_q == CNT_OVR) ? cnt_q : cnt_q + CNT_W'(1);
          end else if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            shreg_d = '0;
            state_d = ST_IDLE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        ST_HOLD: begin
          if (!le_sync) begin
            state_d = ST_IDLE;
            if (clk_rise) begin
              shreg_d = {shreg_q[WORD_W-2:0], si_sync};
              cnt_d   = CNT_W'(1);
              state_d = ST_SHIFT;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    ATT_WORD  = word_q;
    ATT_VALID = valid_q;
    FRAME_ERR = err_q;
    BUSY      = (state_q == ST_SHIFT);
  end

endmodule

// File: tb/tb_att_serial_rx.sv
// Directed bench for att_serial_rx: reset with pins high, nominal frame and
// latency, short/overrun frames, timeout, LE-high masking, coincident
// CLK/LE rise, and mid-frame reset.
module tb_att_serial_rx;

  localparam int WORD_W      = 6;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT_CYC = 1024;

  logic              CLK_ATT = 1'b0;
  logic              RST     = 1'b1;
  logic              SI      = 1'b0;
  logic              CLK     = 1'b0;
  logic              LE      = 1'b0;
  logic [WORD_W-1:0] ATT_WORD;
  logic              ATT_VALID;
  logic              FRAME_ERR;
  logic              BUSY;

  att_serial_rx #(
    .WORD_W      (WORD_W),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .RESET_WORD  (6'h00)
  ) u_dut (
    .CLK_ATT   (CLK_ATT),
    .RST       (RST),
    .SI        (SI),
    .CLK       (CLK),
    .LE        (LE),
    .ATT_WORD  (ATT_WORD),
    .ATT_VALID (ATT_VALID),
    .FRAME_ERR (FRAME_ERR),
    .BUSY      (BUSY)
  );

  always #5 CLK_ATT = ~CLK_ATT;

  int cyc = 0;
  always @(posedge CLK_ATT) cyc <= cyc + 1;

  // Pulse monitor: counts output pulses, sampled mid-cycle.
  int n_valid = 0;
  int n_err   = 0;
  int n_both  = 0;
  int valid_cyc = -1;
  always @(negedge CLK_ATT) begin
    if (!RST) begin
      if (ATT_VALID) begin
        n_valid   = n_valid + 1;
        valid_cyc = cyc;
      end
      if (FRAME_ERR) n_err = n_err + 1;
      if (ATT_VALID && FRAME_ERR) n_both = n_both + 1;
    end
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_mis = n_mis + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK_ATT);
    #1;
  endtask

  // One serial bit: SI set during CLK low, 4-cycle half periods.
  task automatic send_bit(input logic b);
    SI  = b;
    CLK = 1'b0;
    cycles(4);
    CLK = 1'b1;
    cycles(4);
    CLK = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
  endtask

  task automatic pulse_le();
    LE = 1'b1;
    cycles(8);
    LE = 1'b0;
    cycles(8);
  endtask

  int v0, e0, le_cyc;

  initial begin
    // Reset with every pin high, held through release.
    RST = 1'b1; LE = 1'b1; CLK = 1'b1; SI = 1'b1;
    cycles(5);
    RST = 1'b0;
    v0 = n_valid; e0 = n_err;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      if (BUSY !== 1'b0) chk("rst_busy", 32'(BUSY), 32'd0);
    end
    chk("rst_word",  32'(ATT_WORD), 32'h00);
    chk("rst_busy",  32'(BUSY), 32'd0);
    chk("rst_valid", 32'(n_valid - v0), 32'd0);
    chk("rst_err",   32'(n_err - e0), 32'd0);
    LE = 1'b0; CLK = 1'b0; SI = 1'b0;
    cycles(8);

    // Nominal frame 101101 and LE-to-valid latency.
    v0 = n_valid; e0 = n_err;
    send_bits(8'h2D, 6);
    chk("nom_busy", 32'(BUSY), 32'd1);
    LE = 1'b1;
    le_cyc = cyc;
    cycles(8);
    LE = 1'b0;
    cycles(8);
    chk("nom_word",    32'(ATT_WORD), 32'h2D);
    chk("nom_valid",   32'(n_valid - v0), 32'd1);
    chk("nom_latency", 32'(valid_cyc - le_cyc), 32'(SYNC_STAGES + 2));
    chk("nom_err",     32'(n_err - e0), 32'd0);
    chk("nom_idle",    32'(BUSY), 32'd0);

    // Short frame (5 bits).
    v0 = n_valid; e0 = n_err;
    send_bits(8'h1F, 5);
    pulse_le();
    chk("short_err",   32'(n_err - e0), 32'd1);
    chk("short_valid", 32'(n_valid - v0), 32'd0);
    chk("short_word",  32'(ATT_WORD), 32'h2D);

    // Overrun frame (7 bits).
    v0 = n_valid; e0 = n_err;
    send_bits(8'h55, 7);
    pulse_le();
    chk("ovr_err",   32'(n_err - e0), 32'd1);
    chk("ovr_valid", 32'(n_valid - v0), 32'd0);
    chk("ovr_word",  32'(ATT_WORD), 32'h2D);

    // Timeout: 3 bits then silence.
    v0 = n_valid; e0 = n_err;
    send_bits(8'h05, 3);
    cycles(1000);
    chk("tmo_early_err",  32'(n_err - e0), 32'd0);
    chk("tmo_early_busy", 32'(BUSY), 32'd1);
    cycles(100);
    chk("tmo_err",   32'(n_err - e0), 32'd1);
    chk("tmo_busy",  32'(BUSY), 32'd0);
    chk("tmo_valid", 32'(n_valid - v0), 32'd0);
    v0 = n_valid;
    send_bits(8'h3F, 6);
    pulse_le();
    chk("tmo_next_word",  32'(ATT_WORD), 32'h3F);
    chk("tmo_next_valid", 32'(n_valid - v0), 32'd1);

    // CLK pulses while LE is held high are ignored.
    LE = 1'b1;
    cycles(8);
    v0 = n_valid; e0 = n_err;
    send_bits(8'h2A, 6);
    cycles(4);
    chk("lehi_busy",  32'(BUSY), 32'd0);
    chk("lehi_word",  32'(ATT_WORD), 32'h3F);
    chk("lehi_valid", 32'(n_valid - v0), 32'd0);
    chk("lehi_err",   32'(n_err - e0), 32'd0);
    LE = 1'b0;
    cycles(8);

    // Six bits of 010101, then a 7th CLK rise coincident with LE rise.
    v0 = n_valid; e0 = n_err;
    send_bits(8'h15, 6);
    SI = 1'b1;
    cycles(4);
    CLK = 1'b1;
    LE  = 1'b1;
    cycles(8);
    CLK = 1'b0;
    cycles(4);
    LE = 1'b0;
    cycles(8);
    chk("same_word",  32'(ATT_WORD), 32'h15);
    chk("same_valid", 32'(n_valid - v0), 32'd1);
    chk("same_err",   32'(n_err - e0), 32'd0);
    chk("same_busy",  32'(BUSY), 32'd0);

    // Reset in the middle of a frame.
    send_bits(8'h0F, 4);
    RST = 1'b1;
    cycles(3);
    RST = 1'b0;
    v0 = n_valid; e0 = n_err;
    cycles(10);
    chk("mrst_word",  32'(ATT_WORD), 32'h00);
    chk("mrst_busy",  32'(BUSY), 32'd0);
    chk("mrst_valid", 32'(n_valid - v0), 32'd0);
    chk("mrst_err",   32'(n_err - e0), 32'd0);
    send_bits(8'h01, 6);
    pulse_le();
    chk("mrst_next_word",  32'(ATT_WORD), 32'h01);
    chk("mrst_next_valid", 32'(n_valid - v0), 32'd1);

    chk("valid_err_excl", 32'(n_both), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
